// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller: a scoreboard of in-flight destinations drives load-use stalls,
// memory freezes, branch flushes and EX forward selects, with saturating stall/flush counters.

module phs_fwd_sel #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SW         = 2
) (
  input  logic [REG_AW-1:0]                 rs,
  input  logic [FWD_STAGES:1]               ok,
  input  logic [FWD_STAGES:1][REG_AW-1:0]   rd,
  output logic [SW-1:0]                     sel
);
  // Walk oldest to youngest so the youngest eligible producer overrides.
  always_comb begin
    sel = '0;
    for (int k = FWD_STAGES; k >= 1; k--)
      if (ok[k] && rd[k] == rs && rs != '0) sel = SW'(k);
  end
endmodule

module pipe_hazard_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int FWD_STAGES  = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              id_valid,
  input  logic [REG_AW-1:0]                 id_rs1,
  input  logic [REG_AW-1:0]                 id_rs2,
  input  logic                              id_rs1_used,
  input  logic                              id_rs2_used,
  input  logic [REG_AW-1:0]                 id_rd,
  input  logic                              id_regwrite,
  input  logic                              id_memread,
  input  logic                              mem_ready,
  input  logic                              branch_taken,
  output logic                              pc_write,
  output logic                              ifid_write,
  output logic                              idex_bubble,
  output logic [FLUSH_DEPTH-1:0]            flush,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_a,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_b,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic [CNT_W-1:0]                  flush_cnt
);
  localparam int SW = $clog2(FWD_STAGES+1);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              ld;
  } slot_t;

  // Only the ID/EX occupant's sources are ever compared, so they live outside the slot array.
  slot_t             sb     [FWD_STAGES+1];
  slot_t             sb_nxt [FWD_STAGES+1];
  logic [REG_AW-1:0] s0_rs1, s0_rs2, s0_rs1_nxt, s0_rs2_nxt;

  logic load_use, freeze, flush_ev, stall;

  function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] x);
    return s.v & s.rw & (s.rd == x) & (x != '0);
  endfunction

  always_comb begin
    load_use = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++)
      if (sb[j].ld && ((id_rs1_used && hit(sb[j], id_rs1)) ||
                       (id_rs2_used && hit(sb[j], id_rs2))))
        load_use = 1'b1;
    load_use = load_use & id_valid;
  end

  assign freeze   = reset & ~mem_ready;
  assign flush_ev = reset & mem_ready & branch_taken;
  assign stall    = reset & mem_ready & ~branch_taken & load_use;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = '0;
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      flush       = '1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (flush_ev) begin
      idex_bubble = 1'b1;
      flush       = '1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Forward eligibility per slot: loads are not forwardable until slot 1+LOAD_LAT.
  logic [FWD_STAGES:1]             src_ok;
  logic [FWD_STAGES:1][REG_AW-1:0] src_rd;
  logic [1:0][REG_AW-1:0]          op_rs;
  logic [1:0][SW-1:0]              op_sel;

  for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_src
    assign src_ok[k] = sb[k].v & sb[k].rw & ~(sb[k].ld & (k < LOAD_LAT+1));
    assign src_rd[k] = sb[k].rd;
  end

  assign op_rs[0] = s0_rs1;
  assign op_rs[1] = s0_rs2;

  for (genvar i = 0; i < 2; i++) begin : g_op
    phs_fwd_sel #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SW(SW)) u_sel (
      .rs  (op_rs[i]),
      .ok  (src_ok),
      .rd  (src_rd),
      .sel (op_sel[i])
    );
  end

  assign fwd_a = reset ? op_sel[0] : '0;
  assign fwd_b = reset ? op_sel[1] : '0;

  always_comb begin
    for (int k = 0; k <= FWD_STAGES; k++) sb_nxt[k] = sb[k];
    s0_rs1_nxt = s0_rs1;
    s0_rs2_nxt = s0_rs2;
    if (mem_ready) begin
      for (int k = 1; k <= FWD_STAGES; k++) sb_nxt[k] = sb[k-1];
      if (branch_taken || load_use) begin
        sb_nxt[0]  = '0;
        s0_rs1_nxt = '0;
        s0_rs2_nxt = '0;
      end else begin
        sb_nxt[0]  = '{v: id_valid, rd: id_rd, rw: id_regwrite, ld: id_memread};
        s0_rs1_nxt = id_rs1;
        s0_rs2_nxt = id_rs2;
      end
      // Wrong-path instructions that shifted into the younger slots are killed.
      if (branch_taken)
        for (int k = 0; k < FLUSH_DEPTH-1 && k <= FWD_STAGES; k++) sb_nxt[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k <= FWD_STAGES; k++) sb[k] <= '0;
      s0_rs1    <= '0;
      s0_rs2    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = 0; k <= FWD_STAGES; k++) sb[k] <= sb_nxt[k];
      s0_rs1 <= s0_rs1_nxt;
      s0_rs2 <= s0_rs2_nxt;
      if ((freeze || stall) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1)          flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
